// File: rtl/display_pkg.sv
// Shared types and constants for the product display: FSM encoding,
// active-low seven-segment patterns and a width-check helper.
package display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_COMMIT  = 2'd2
   } state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Bit order {g,f,e,d,c,b,a}; a 0 lights the segment.
   localparam logic [6:0] SEG_DIGITS [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-low seven-segment decode with a
// blank override; codes 10-15 decode to all segments off.
module seg7_decoder
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank && (nibble <= 4'd9)) seg = SEG_DIGITS[nibble];
   end

endmodule

// File: rtl/product_display.sv
// Converts a captured binary product to BCD with a shift-add-3 engine and
// scans the committed digits onto a multiplexed seven-segment display.
module product_display
   import display_pkg::*;
#(
   parameter int W           = 8,
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_LZ    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [W-1:0]      value,
   output logic              busy,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an,
   output logic              dp
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
   localparam int REF_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   if (((64'd1 << W) - 64'd1) > (pow10(DIGITS) - 64'd1)) begin : g_bad_width
      $error("product_display: W=%0d does not fit in %0d decimal digits", W, DIGITS);
   end
   if (REFRESH_DIV < 2) begin : g_bad_refresh
      $error("product_display: REFRESH_DIV must be at least 2");
   end

   state_e             state_q, state_d;
   logic [W-1:0]       bin_q, bin_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
   logic [BCD_W-1:0]   disp_q, disp_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [REF_W-1:0]   ref_q, ref_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [6:0]         seg_q, dec_seg;
   logic [DIGITS-1:0]  an_q, an_d;
   logic [3:0]         sel_nibble;
   logic               sel_blank;
   logic [BCD_W-1:0]   upper;

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      disp_d  = disp_q;
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               state_d = ST_CONVERT;
               bin_d   = value;
               bcd_d   = '0;
               cnt_d   = '0;
            end
         end
         ST_CONVERT: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(W - 1)) state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            disp_d  = bcd_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Segments are chosen for the index that will be live after this edge, so
   // an and seg always move together.
   always_comb begin
      ref_d = ref_q + 1'b1;
      idx_d = idx_q;
      if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
         ref_d = '0;
         idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
      sel_nibble = disp_q[4*idx_d +: 4];
      upper      = disp_q >> (4 * idx_d);
      sel_blank  = (BLANK_LZ != 0) && (idx_d != '0) && (upper == '0);
      an_d          = '1;
      an_d[idx_d]   = 1'b0;
   end

   seg7_decoder u_dec (
      .nibble (sel_nibble),
      .blank  (sel_blank),
      .seg    (dec_seg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         disp_q  <= '0;
         ref_q   <= '0;
         idx_q   <= '0;
         seg_q   <= SEG_DIGITS[0];
         an_q    <= ~DIGITS'(1);
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         ref_q   <= ref_d;
         idx_q   <= idx_d;
         seg_q   <= dec_seg;
         an_q    <= an_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign seg  = seg_q;
   assign an   = an_q;
   assign dp   = 1'b1;

endmodule

// File: tb/tb_product_display.sv
// Bench for product_display: directed scenarios plus a shuffled sweep of all
// products, checked cycle by cycle against a decimal reference model.
module tb_product_display;

   localparam int W           = 8;
   localparam int DIGITS      = 4;
   localparam int REFRESH_DIV = 4;
   localparam int BLANK_LZ    = 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              load = 1'b0;
   logic [W-1:0]      value = '0;
   logic              busy;
   logic [6:0]        seg;
   logic [DIGITS-1:0] an;
   logic              dp;

   product_display #(
      .W           (W),
      .DIGITS      (DIGITS),
      .REFRESH_DIV (REFRESH_DIV),
      .BLANK_LZ    (BLANK_LZ)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .value (value),
      .busy  (busy),
      .seg   (seg),
      .an    (an),
      .dp    (dp)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   int           exp_edge_q[$];
   int           edge_n = -1;
   bit           acc_valid = 1'b0;
   int           acc_edge = 0;

   function automatic logic [6:0] seg_ref(input int d);
      string      lit;
      logic [6:0] s;
      case (d)
         0: lit = "abcdef";
         1: lit = "bc";
         2: lit = "abdeg";
         3: lit = "abcdg";
         4: lit = "bcfg";
         5: lit = "acdfg";
         6: lit = "acdefg";
         7: lit = "abc";
         8: lit = "abcdefg";
         9: lit = "abcdfg";
         default: lit = "";
      endcase
      s = 7'h7F;
      for (int i = 0; i < lit.len(); i++) s[int'(lit[i]) - 97] = 1'b0;
      return s;
   endfunction

   function automatic int pow10i(input int n);
      int p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, req);
      end
   endtask

   // Monitor: scan position and shown number are derived from cycle counts
   // and committed values, then compared with the pins after every edge.
   initial begin : monitor
      bit         started;
      bit         rst_s;
      bit         busy_prev;
      int         k;
      int         shown;
      int         idx;
      int         digit;
      int         e0;
      bit         busy_exp;
      logic [6:0] seg_exp;
      logic [DIGITS-1:0] an_exp;
      logic [W-1:0] v;
      started = 1'b0;
      busy_prev = 1'b0;
      k = 0;
      shown = 0;
      forever begin
         @(posedge clk);
         edge_n++;
         rst_s = rst;
         #1;
         if (rst_s) begin
            started = 1'b1;
            k = 0;
            shown = 0;
         end else begin
            k++;
         end
         if (started) begin
            idx     = (k / REFRESH_DIV) % DIGITS;
            an_exp  = ~(DIGITS'(1) << idx);
            digit   = (shown / pow10i(idx)) % 10;
            seg_exp = (BLANK_LZ != 0 && idx > 0 && shown < pow10i(idx)) ? 7'h7F : seg_ref(digit);
            busy_exp = !rst_s && acc_valid && (edge_n - acc_edge) >= 0 && (edge_n - acc_edge) <= W;
            check("an", an, an_exp);
            check("seg", seg, seg_exp);
            check("busy", busy, busy_exp);
            check("dp", dp, 1);
            if (busy_prev && !busy && !rst_s) begin
               check("commit_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  v  = exp_q.pop_front();
                  e0 = exp_edge_q.pop_front();
                  check("latency", edge_n - e0, W + 1);
                  shown = int'(v);
               end
            end
            busy_prev = busy;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input logic [W-1:0] v);
      int up;
      @(negedge clk);
      up = edge_n + 1;
      if (!acc_valid || (up - acc_edge) >= W + 2) begin
         acc_valid = 1'b1;
         acc_edge  = up;
         exp_q.push_back(v);
         exp_edge_q.push_back(up);
      end
      load  = 1'b1;
      value = v;
      @(negedge clk);
      load  = 1'b0;
      value = W'($urandom_range(0, (1 << W) - 1));
   endtask

   task automatic apply_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      acc_valid = 1'b0;
      exp_q.delete();
      exp_edge_q.delete();
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_clear(input int extra);
      while (acc_valid && (edge_n + 1 - acc_edge) < W + 2 + extra) @(negedge clk);
   endtask

   initial begin : stimulus
      int order[256];
      int j;
      int tmp;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(20);

      do_load(8'd225);
      idle(30);
      do_load(8'd255);
      idle(30);
      do_load(8'd0);
      idle(30);

      do_load(8'd100);
      idle(1);
      do_load(8'd7);
      idle(30);

      do_load(8'd99);
      idle(2);
      apply_reset(2);
      idle(5);
      do_load(8'd42);
      idle(30);

      @(negedge clk);
      rst  = 1'b1;
      load = 1'b1;
      value = 8'd77;
      acc_valid = 1'b0;
      @(negedge clk);
      rst  = 1'b0;
      load = 1'b0;
      idle(20);

      for (int i = 0; i < 256; i++) order[i] = i;
      for (int i = 255; i > 0; i--) begin
         j = int'($urandom_range(0, i));
         tmp = order[i];
         order[i] = order[j];
         order[j] = tmp;
      end
      for (int i = 0; i < 256; i++) begin
         wait_clear(int'($urandom_range(8, 16)));
         do_load(W'(order[i]));
         if ($urandom_range(0, 3) == 0) begin
            idle(int'($urandom_range(0, W - 3)));
            do_load(W'($urandom_range(0, (1 << W) - 1)));
         end
      end
      idle(40);

      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
